// File: rtl/vend_pkg.sv
// Shared types for the vending dispense sequencer.
//   state_e  : sequencer FSM states (also exported on the debug port)
//   change_e : change codes carried by a vending event
//   fault_e  : fault codes reported on fault_code_o
//   evt_t    : one queued event {vend, change}
//   coins_of : number of 5-rs coins owed for a change code
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DISPENSE = 3'd1,
    ST_COIN     = 3'd2,
    ST_GAP      = 3'd3,
    ST_FAULT    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CHG_NONE    = 2'b00,
    CHG_5       = 2'b01,
    CHG_10      = 2'b10,
    CHG_ILLEGAL = 2'b11
  } change_e;

  typedef enum logic [1:0] {
    FLT_NONE = 2'b00,
    FLT_DISP = 2'b01,
    FLT_HOP  = 2'b10
  } fault_e;

  typedef struct packed {
    logic       vend;
    logic [1:0] change;
  } evt_t;

  function automatic logic [1:0] coins_of(input logic [1:0] change);
    logic [1:0] n;
    n = 2'd0;
    if (change == CHG_5)  n = 2'd1;
    if (change == CHG_10) n = 2'd2;
    return n;
  endfunction

endpackage

// File: rtl/vend_evt_fifo.sv
// Event FIFO, QDEPTH entries of evt_t, synchronous.
//   clk, rst   : clock, synchronous active-high reset
//   push_i     : write wdata_i (ignored when full)
//   pop_i      : drop head entry (ignored when empty)
//   flush_i    : discard all entries
//   rdata_o    : head entry (valid when !empty_o)
//   full_o, empty_o, count_o : occupancy status
module vend_evt_fifo
  import vend_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  evt_t                     wdata_i,
  output evt_t                     rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(QDEPTH):0]  count_o
);

  localparam int AW = $clog2(QDEPTH);

  evt_t          mem_q [QDEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(QDEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers wrap naturally because QDEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/vend_dispense_sequencer.sv
// Drives the bottle dispenser and 5-rs coin hopper from queued vending
// events, with per-handshake timeout supervision.
//   clk, rst                 : clock, synchronous active-high reset
//   evt_valid_i/vend/change  : event from vending FSM; evt_ready_o accepts
//   evt_err_o                : pulse after an illegal change code is offered
//   disp_req_o / disp_ack_i  : dispenser handshake
//   hop_req_o / hop_ack_i    : hopper handshake, one coin each
//   vend_done_o, coin_done_o : one pulse per completed bottle / coin
//   clear_fault_i            : leave FAULT, flushing the queue
//   fault_o, fault_code_o    : sticky fault and its cause
//   busy_o, count_o          : activity and queue occupancy
//   dbg_state_o              : current FSM state
//
// Handshakes: an event transfers on a clock edge where evt_valid_i and
// evt_ready_o are both high. An actuator req stays high until the edge
// where its ack is sampled high; acks are ignored while their req is low.
module vend_dispense_sequencer
  import vend_pkg::*;
#(
  parameter int QDEPTH  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     evt_valid_i,
  input  logic                     evt_vend_i,
  input  logic [1:0]               evt_change_i,
  output logic                     evt_ready_o,
  output logic                     evt_err_o,
  output logic                     disp_req_o,
  input  logic                     disp_ack_i,
  output logic                     hop_req_o,
  input  logic                     hop_ack_i,
  output logic                     vend_done_o,
  output logic                     coin_done_o,
  input  logic                     clear_fault_i,
  output logic                     fault_o,
  output logic [1:0]               fault_code_o,
  output logic                     busy_o,
  output logic [$clog2(QDEPTH):0]  count_o,
  output state_e                   dbg_state_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    coins_q, coins_d;
  logic [1:0]    fault_code_q, fault_code_d;
  logic          vend_done_q, vend_done_d;
  logic          coin_done_q, coin_done_d;
  logic          err_q;

  logic fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  evt_t fifo_head, fifo_wdata;

  assign evt_ready_o = ~fifo_full & (state_q != ST_FAULT);
  assign fifo_wdata  = '{vend: evt_vend_i, change: evt_change_i};
  // Events that ask for nothing are dropped rather than queued.
  assign fifo_push   = evt_valid_i & evt_ready_o &
                       (evt_change_i != CHG_ILLEGAL) &
                       (evt_vend_i | (evt_change_i != CHG_NONE));

  vend_evt_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      coins_q      <= '0;
      fault_code_q <= FLT_NONE;
      vend_done_q  <= 1'b0;
      coin_done_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      coins_q      <= coins_d;
      fault_code_q <= fault_code_d;
      vend_done_q  <= vend_done_d;
      coin_done_q  <= coin_done_d;
      err_q        <= evt_valid_i & evt_ready_o & (evt_change_i == CHG_ILLEGAL);
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    coins_d      = coins_q;
    fault_code_d = fault_code_q;
    vend_done_d  = 1'b0;
    coin_done_d  = 1'b0;
    fifo_pop     = 1'b0;
    fifo_flush   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          coins_d  = coins_of(fifo_head.change);
          timer_d  = '0;
          state_d  = fifo_head.vend ? ST_DISPENSE : ST_COIN;
        end
      end
      ST_DISPENSE: begin
        if (disp_ack_i) begin
          vend_done_d = 1'b1;
          state_d     = (coins_q != 2'd0) ? ST_GAP : ST_IDLE;
        end else if (timer_q == TW'(TIMEOUT)) begin
          state_d      = ST_FAULT;
          fault_code_d = FLT_DISP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_COIN: begin
        if (hop_ack_i) begin
          coin_done_d = 1'b1;
          coins_d     = coins_q - 2'd1;
          state_d     = (coins_q > 2'd1) ? ST_GAP : ST_IDLE;
        end else if (timer_q == TW'(TIMEOUT)) begin
          state_d      = ST_FAULT;
          fault_code_d = FLT_HOP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_GAP: begin
        timer_d = '0;
        state_d = ST_COIN;
      end
      ST_FAULT: begin
        if (clear_fault_i) begin
          fifo_flush   = 1'b1;
          fault_code_d = FLT_NONE;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign disp_req_o   = (state_q == ST_DISPENSE);
  assign hop_req_o    = (state_q == ST_COIN);
  assign fault_o      = (state_q == ST_FAULT);
  assign fault_code_o = fault_code_q;
  assign vend_done_o  = vend_done_q;
  assign coin_done_o  = coin_done_q;
  assign evt_err_o    = err_q;
  assign busy_o       = (state_q != ST_IDLE) | ~fifo_empty;
  assign dbg_state_o  = state_q;

endmodule
